// File: rtl/stream_rate_monitor.sv
// ---------------------------------------------------------------------------
// stream_rate_monitor
//
// Purpose:
//   Zero-latency AXI4-Stream video tap. The stream passes straight through
//   while the block measures the frame geometry (pixels per line, lines per
//   frame), counts frames, and gathers per-window rates (frames, beats and
//   optionally stalls) over a programmable window of clock cycles. A small
//   strobe/ack register port exposes control, sticky status and the results.
//
// Optional feature:
//   Define STREAM_RATE_MONITOR_STALL_COUNT_EN to build STALLS_PER_WINDOW
//   (address 8) and STATUS.STALL_SEEN (bit 4). Without the macro, address 8
//   reads 0 as a valid register and bit 4 reads 0.
//
// Ports:
//   i_axi_clk, i_axi_rst          clock, asynchronous active-high reset
//   i_axis_in_*, o_axis_in_tready ingress stream (tuser marks start of frame)
//   o_axis_out_*, i_axis_out_tready egress stream (combinational copy)
//   i_reg_wr_stb, i_reg_rd_stb    one-cycle register access strobes
//   i_reg_addr, i_reg_wr_data     word address and write data
//   o_reg_ack                     one-cycle ack, one cycle after a strobe
//   o_reg_rd_data                 read data, valid with ack, held until next read
//   o_reg_invalid                 pulses with ack for addresses above 9
//
// Register map (word addresses):
//   0 CONTROL (bit0 W1 clear counts, bit1 enable)   5 BEATS_PER_WINDOW
//   1 STATUS  (W1C: 0 FRAME_SEEN, 1 ROW_MISMATCH,    6 LINES_PER_FRAME
//             2 LINE_MISMATCH, 3 EARLY_SOF,          7 PIXELS_PER_LINE
//             4 STALL_SEEN)                          8 STALLS_PER_WINDOW
//   2 WINDOW                                         9 VERSION (0x11000000)
//   3 TOTAL_FRAMES
//   4 FRAMES_PER_WINDOW
// ---------------------------------------------------------------------------
module stream_rate_monitor #(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned DATA_WIDTH      = 24,
    parameter int unsigned COUNT_WIDTH     = 32,
    parameter int unsigned DIM_WIDTH       = 16,
    parameter int unsigned REG_ADDR_WIDTH  = 4
) (
    input  logic                      i_axi_clk,
    input  logic                      i_axi_rst,

    input  logic                      i_axis_in_tuser,
    input  logic                      i_axis_in_tvalid,
    input  logic                      i_axis_in_tlast,
    output logic                      o_axis_in_tready,
    input  logic [DATA_WIDTH-1:0]     i_axis_in_tdata,

    output logic                      o_axis_out_tuser,
    output logic                      o_axis_out_tvalid,
    output logic                      o_axis_out_tlast,
    input  logic                      i_axis_out_tready,
    output logic [DATA_WIDTH-1:0]     o_axis_out_tdata,

    input  logic                      i_reg_wr_stb,
    input  logic                      i_reg_rd_stb,
    input  logic [REG_ADDR_WIDTH-1:0] i_reg_addr,
    input  logic [31:0]               i_reg_wr_data,
    output logic                      o_reg_ack,
    output logic [31:0]               o_reg_rd_data,
    output logic                      o_reg_invalid
);

    localparam logic [31:0] ADDR_CONTROL      = 32'd0;
    localparam logic [31:0] ADDR_STATUS       = 32'd1;
    localparam logic [31:0] ADDR_WINDOW       = 32'd2;
    localparam logic [31:0] ADDR_TOTAL_FRAMES = 32'd3;
    localparam logic [31:0] ADDR_FRAMES_PW    = 32'd4;
    localparam logic [31:0] ADDR_BEATS_PW     = 32'd5;
    localparam logic [31:0] ADDR_LINES_PF     = 32'd6;
    localparam logic [31:0] ADDR_PIXELS_PL    = 32'd7;
    localparam logic [31:0] ADDR_STALLS_PW    = 32'd8;
    localparam logic [31:0] ADDR_VERSION      = 32'd9;
    localparam logic [31:0] VERSION_ID        = 32'h1100_0000;

    localparam logic [DIM_WIDTH-1:0]   DIM_ONE = DIM_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Stream pass-through
    // ------------------------------------------------------------------
    assign o_axis_out_tuser  = i_axis_in_tuser;
    assign o_axis_out_tvalid = i_axis_in_tvalid;
    assign o_axis_out_tlast  = i_axis_in_tlast;
    assign o_axis_out_tdata  = i_axis_in_tdata;
    assign o_axis_in_tready  = i_axis_out_tready;

    logic beat;
    logic sof;
    assign beat = i_axis_in_tvalid & i_axis_out_tready;
    assign sof  = beat & i_axis_in_tuser;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic [31:0] addr_ext;
    logic        addr_invalid;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_window;
    logic        ctrl_clear;
    logic        ctrl_enable_q;

    always_comb begin
        addr_ext = '0;
        addr_ext[REG_ADDR_WIDTH-1:0] = i_reg_addr;
    end

    assign addr_invalid = (addr_ext > ADDR_VERSION);
    assign wr_ctrl      = i_reg_wr_stb && (addr_ext == ADDR_CONTROL);
    assign wr_status    = i_reg_wr_stb && (addr_ext == ADDR_STATUS);
    assign wr_window    = i_reg_wr_stb && (addr_ext == ADDR_WINDOW);
    assign ctrl_clear   = wr_ctrl && i_reg_wr_data[0];

    // ------------------------------------------------------------------
    // Frame geometry
    // ------------------------------------------------------------------
    logic [DIM_WIDTH-1:0]   pix_cnt_q;
    logic [DIM_WIDTH-1:0]   line_cnt_q;
    logic [DIM_WIDTH-1:0]   pixels_pl_q;
    logic [DIM_WIDTH-1:0]   lines_pf_q;
    logic [COUNT_WIDTH-1:0] total_frames_q;

    logic [DIM_WIDTH-1:0]   pix_start;
    logic [DIM_WIDTH-1:0]   line_start;
    logic [DIM_WIDTH-1:0]   pix_inc;
    logic [DIM_WIDTH-1:0]   line_inc;

    // An SOF beat is pixel 0 of line 0, so counting restarts from zero
    // before this beat is added.
    always_comb begin
        pix_start  = sof ? '0 : pix_cnt_q;
        line_start = sof ? '0 : line_cnt_q;
        pix_inc    = (pix_start  == '1) ? pix_start  : pix_start  + DIM_ONE;
        line_inc   = (line_start == '1) ? line_start : line_start + DIM_ONE;
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            pixels_pl_q    <= '0;
            lines_pf_q     <= '0;
            total_frames_q <= '0;
        end else begin
            if (ctrl_enable_q && beat) begin
                if (i_axis_in_tlast) begin
                    pixels_pl_q <= pix_inc;
                    pix_cnt_q   <= '0;
                    line_cnt_q  <= line_inc;
                end else begin
                    pix_cnt_q   <= pix_inc;
                    line_cnt_q  <= line_start;
                end
                if (sof) begin
                    lines_pf_q <= line_cnt_q;
                end
            end
            if (ctrl_clear) begin
                total_frames_q <= '0;
            end else if (ctrl_enable_q && sof && (total_frames_q != '1)) begin
                total_frames_q <= total_frames_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status (bits 3:0); a set event beats a same-cycle clear
    // ------------------------------------------------------------------
    logic [3:0] status_q;
    logic [3:0] status_set;
    logic [3:0] status_clr;

    always_comb begin
        status_set    = '0;
        status_set[0] = ctrl_enable_q && sof;
        status_set[1] = ctrl_enable_q && beat && i_axis_in_tlast &&
                        (pixels_pl_q != '0) && (pixels_pl_q != pix_inc);
        status_set[2] = ctrl_enable_q && sof &&
                        (lines_pf_q != '0) && (lines_pf_q != line_cnt_q);
        status_set[3] = ctrl_enable_q && sof && (pix_cnt_q != '0);
        status_clr    = wr_status ? i_reg_wr_data[3:0] : '0;
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~status_clr) | status_set;
        end
    end

    // ------------------------------------------------------------------
    // Measurement window
    // ------------------------------------------------------------------
    logic [31:0]            window_q;
    logic [31:0]            win_cnt_q;
    logic                   win_active;
    logic                   win_last;
    logic [COUNT_WIDTH-1:0] frames_run_q;
    logic [COUNT_WIDTH-1:0] beats_run_q;
    logic [COUNT_WIDTH-1:0] frames_run_nx;
    logic [COUNT_WIDTH-1:0] beats_run_nx;
    logic [COUNT_WIDTH-1:0] frames_pw_q;
    logic [COUNT_WIDTH-1:0] beats_pw_q;

    // A window of 0 or 1 cycles never latches.
    assign win_active = (window_q > 32'd1);
    assign win_last   = ctrl_enable_q && win_active && (win_cnt_q == window_q - 32'd1);

    // Running counts including this cycle's event, so the terminal cycle is
    // part of the latched result.
    always_comb begin
        frames_run_nx = (sof  && (frames_run_q != '1)) ? frames_run_q + CNT_ONE : frames_run_q;
        beats_run_nx  = (beat && (beats_run_q  != '1)) ? beats_run_q  + CNT_ONE : beats_run_q;
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            ctrl_enable_q <= 1'b1;
            window_q      <= 32'(CLOCK_FREQUENCY);
            win_cnt_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable_q <= i_reg_wr_data[1];
            end
            if (wr_window) begin
                window_q  <= i_reg_wr_data;
                win_cnt_q <= '0;
            end else if (ctrl_enable_q) begin
                if (!win_active || win_last) begin
                    win_cnt_q <= '0;
                end else begin
                    win_cnt_q <= win_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            frames_run_q <= '0;
            beats_run_q  <= '0;
            frames_pw_q  <= '0;
            beats_pw_q   <= '0;
        end else begin
            if (wr_window || ctrl_clear) begin
                frames_run_q <= '0;
                beats_run_q  <= '0;
            end else if (ctrl_enable_q) begin
                if (win_last) begin
                    frames_pw_q  <= frames_run_nx;
                    beats_pw_q   <= beats_run_nx;
                    frames_run_q <= '0;
                    beats_run_q  <= '0;
                end else begin
                    frames_run_q <= frames_run_nx;
                    beats_run_q  <= beats_run_nx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
    logic        stall_seen_bit;
    logic [31:0] stalls_pw_word;

`ifdef STREAM_RATE_MONITOR_STALL_COUNT_EN
    logic                   stall;
    logic                   stall_seen_q;
    logic [COUNT_WIDTH-1:0] stalls_run_q;
    logic [COUNT_WIDTH-1:0] stalls_run_nx;
    logic [COUNT_WIDTH-1:0] stalls_pw_q;

    assign stall         = i_axis_in_tvalid & ~i_axis_out_tready;
    assign stalls_run_nx = (stall && (stalls_run_q != '1)) ? stalls_run_q + CNT_ONE : stalls_run_q;

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            stall_seen_q <= 1'b0;
            stalls_run_q <= '0;
            stalls_pw_q  <= '0;
        end else begin
            stall_seen_q <= (stall_seen_q & ~(wr_status & i_reg_wr_data[4])) |
                            (ctrl_enable_q & stall);
            if (wr_window || ctrl_clear) begin
                stalls_run_q <= '0;
            end else if (ctrl_enable_q) begin
                if (win_last) begin
                    stalls_pw_q  <= stalls_run_nx;
                    stalls_run_q <= '0;
                end else begin
                    stalls_run_q <= stalls_run_nx;
                end
            end
        end
    end

    assign stall_seen_bit = stall_seen_q;
    assign stalls_pw_word = 32'(stalls_pw_q);
`else
    assign stall_seen_bit = 1'b0;
    assign stalls_pw_word = '0;
`endif

    // ------------------------------------------------------------------
    // Register read and handshake
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;
    logic        rd_take;

    // A write on the same cycle wins; the read is dropped.
    assign rd_take = i_reg_rd_stb && !i_reg_wr_stb;

    always_comb begin
        rd_mux = '0;
        case (addr_ext)
            ADDR_CONTROL:      rd_mux = {30'd0, ctrl_enable_q, 1'b0};
            ADDR_STATUS:       rd_mux = {27'd0, stall_seen_bit, status_q};
            ADDR_WINDOW:       rd_mux = window_q;
            ADDR_TOTAL_FRAMES: rd_mux = 32'(total_frames_q);
            ADDR_FRAMES_PW:    rd_mux = 32'(frames_pw_q);
            ADDR_BEATS_PW:     rd_mux = 32'(beats_pw_q);
            ADDR_LINES_PF:     rd_mux = 32'(lines_pf_q);
            ADDR_PIXELS_PL:    rd_mux = 32'(pixels_pl_q);
            ADDR_STALLS_PW:    rd_mux = stalls_pw_word;
            ADDR_VERSION:      rd_mux = VERSION_ID;
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            o_reg_ack     <= 1'b0;
            o_reg_invalid <= 1'b0;
            o_reg_rd_data <= '0;
        end else begin
            o_reg_ack     <= i_reg_wr_stb | i_reg_rd_stb;
            o_reg_invalid <= (i_reg_wr_stb | i_reg_rd_stb) & addr_invalid;
            if (rd_take) begin
                o_reg_rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_stream_rate_monitor.sv
// ---------------------------------------------------------------------------
// tb_stream_rate_monitor
//
// Directed bench for stream_rate_monitor. Inputs change on the falling edge,
// the DUT samples on the rising edge, outputs are read on the next falling
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_stream_rate_monitor;

    logic        i_axi_clk = 1'b0;
    logic        i_axi_rst = 1'b1;
    logic        i_axis_in_tuser = 1'b0;
    logic        i_axis_in_tvalid = 1'b0;
    logic        i_axis_in_tlast = 1'b0;
    logic        o_axis_in_tready;
    logic [23:0] i_axis_in_tdata = '0;
    logic        o_axis_out_tuser;
    logic        o_axis_out_tvalid;
    logic        o_axis_out_tlast;
    logic        i_axis_out_tready = 1'b1;
    logic [23:0] o_axis_out_tdata;
    logic        i_reg_wr_stb = 1'b0;
    logic        i_reg_rd_stb = 1'b0;
    logic [3:0]  i_reg_addr = '0;
    logic [31:0] i_reg_wr_data = '0;
    logic        o_reg_ack;
    logic [31:0] o_reg_rd_data;
    logic        o_reg_invalid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] rd;
    logic        last_ack;
    logic        last_inv;

    stream_rate_monitor #(
        .CLOCK_FREQUENCY (100000000),
        .DATA_WIDTH      (24),
        .COUNT_WIDTH     (32),
        .DIM_WIDTH       (16),
        .REG_ADDR_WIDTH  (4)
    ) dut (
        .i_axi_clk         (i_axi_clk),
        .i_axi_rst         (i_axi_rst),
        .i_axis_in_tuser   (i_axis_in_tuser),
        .i_axis_in_tvalid  (i_axis_in_tvalid),
        .i_axis_in_tlast   (i_axis_in_tlast),
        .o_axis_in_tready  (o_axis_in_tready),
        .i_axis_in_tdata   (i_axis_in_tdata),
        .o_axis_out_tuser  (o_axis_out_tuser),
        .o_axis_out_tvalid (o_axis_out_tvalid),
        .o_axis_out_tlast  (o_axis_out_tlast),
        .i_axis_out_tready (i_axis_out_tready),
        .o_axis_out_tdata  (o_axis_out_tdata),
        .i_reg_wr_stb      (i_reg_wr_stb),
        .i_reg_rd_stb      (i_reg_rd_stb),
        .i_reg_addr        (i_reg_addr),
        .i_reg_wr_data     (i_reg_wr_data),
        .o_reg_ack         (o_reg_ack),
        .o_reg_rd_data     (o_reg_rd_data),
        .o_reg_invalid     (o_reg_invalid)
    );

    always #5 i_axi_clk = ~i_axi_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        i_reg_wr_stb  = 1'b1;
        i_reg_addr    = addr;
        i_reg_wr_data = data;
        @(negedge i_axi_clk);
        i_reg_wr_stb  = 1'b0;
        last_ack = o_reg_ack;
        last_inv = o_reg_invalid;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
        i_reg_rd_stb = 1'b1;
        i_reg_addr   = addr;
        @(negedge i_axi_clk);
        i_reg_rd_stb = 1'b0;
        data     = o_reg_rd_data;
        last_ack = o_reg_ack;
        last_inv = o_reg_invalid;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        reg_read(addr, v);
        check(tag, v, exp);
    endtask

    task automatic beat(input logic user, input logic last);
        i_axis_in_tvalid = 1'b1;
        i_axis_in_tuser  = user;
        i_axis_in_tlast  = last;
        i_axis_in_tdata  = i_axis_in_tdata + 24'd1;
        @(negedge i_axi_clk);
        i_axis_in_tvalid = 1'b0;
        i_axis_in_tuser  = 1'b0;
        i_axis_in_tlast  = 1'b0;
    endtask

    task automatic send_line(input int unsigned n, input logic first_sof);
        for (int unsigned i = 0; i < n; i++) begin
            beat(first_sof && (i == 0), i == n - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge i_axi_clk);
        check("rst_ack", {31'd0, o_reg_ack}, 32'd0);
        check("rst_rd_data", o_reg_rd_data, 32'd0);
        i_axi_rst = 1'b0;
        @(negedge i_axi_clk);
        read_check("rst_status", 4'd1, 32'd0);
        read_check("rst_window", 4'd2, 32'd100000000);
        read_check("rst_control", 4'd0, 32'd2);
        read_check("rst_total_frames", 4'd3, 32'd0);
        read_check("version", 4'd9, 32'h1100_0000);
        check("read_ack", {31'd0, last_ack}, 32'd1);

        // ---------------- pass-through (within low phase, no edge) --------
        i_axis_in_tvalid = 1'b1; i_axis_in_tuser = 1'b1; i_axis_in_tlast = 1'b1;
        i_axis_in_tdata = 24'hABCDEF; i_axis_out_tready = 1'b0;
        #1;
        check("pt_tdata", {8'd0, o_axis_out_tdata}, 32'h00ABCDEF);
        check("pt_ctrl", {28'd0, o_axis_out_tvalid, o_axis_out_tuser, o_axis_out_tlast, o_axis_in_tready}, 32'hE);
        i_axis_in_tvalid = 1'b0; i_axis_in_tuser = 1'b0; i_axis_in_tlast = 1'b0;
        i_axis_out_tready = 1'b1;

        // ---------------- 3 frames x 4 lines x 8 beats ----------------
        @(negedge i_axi_clk);
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < 4; l++)
                send_line(8, l == 0);
        read_check("ppl_8", 4'd7, 32'd8);
        read_check("lpf_4", 4'd6, 32'd4);
        read_check("total_frames_3", 4'd3, 32'd3);
        read_check("status_frames", 4'd1, 32'h1);

        // ---------------- short line -> row mismatch ----------------
        send_line(7, 1'b0);
        read_check("ppl_7", 4'd7, 32'd7);
        read_check("status_row_mm", 4'd1, 32'h3);
        reg_write(4'd1, 32'h2);
        read_check("status_w1c", 4'd1, 32'h1);

        // ---------------- SOF at pixel 3 ----------------
        reg_write(4'd1, 32'h1F);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0);
        send_line(8, 1'b1);
        read_check("early_sof_status", 4'd1, 32'hF);
        read_check("early_sof_ppl", 4'd7, 32'd8);
        beat(1'b1, 1'b0);
        read_check("early_sof_lpf", 4'd6, 32'd1);
        read_check("total_frames_5", 4'd3, 32'd5);
        reg_write(4'd0, 32'h3);
        read_check("ctrl_clear_tf", 4'd3, 32'd0);
        read_check("ctrl_enable_kept", 4'd0, 32'd2);

        // ---------------- WINDOW=100, 10-beat bursts, last at cycle 99 ------
        reg_write(4'd2, 32'd100);
        for (int c = 0; c < 100; c++) begin
            i_axis_in_tvalid = ((c % 20) >= 10);
            i_axis_in_tuser  = (c == 10);
            @(negedge i_axi_clk);
        end
        i_axis_in_tvalid = 1'b0; i_axis_in_tuser = 1'b0;
        read_check("beats_pw_50", 4'd5, 32'd50);
        read_check("frames_pw_1", 4'd4, 32'd1);

        // ---------------- WINDOW=0 holds results ----------------
        reg_write(4'd2, 32'd0);
        for (int c = 0; c < 150; c++) begin
            i_axis_in_tvalid = ((c % 3) == 0);
            @(negedge i_axi_clk);
        end
        i_axis_in_tvalid = 1'b0;
        read_check("window_0", 4'd2, 32'd0);
        read_check("beats_pw_hold", 4'd5, 32'd50);

        // ---------------- stalls ----------------
        reg_write(4'd1, 32'h1F);
        reg_write(4'd2, 32'd100);
        for (int c = 0; c < 100; c++) begin
            i_axis_in_tvalid  = (c >= 10 && c < 15);
            i_axis_out_tready = !(c >= 10 && c < 15);
            @(negedge i_axi_clk);
        end
        i_axis_in_tvalid = 1'b0; i_axis_out_tready = 1'b1;
        read_check("beats_pw_0", 4'd5, 32'd0);
`ifdef STREAM_RATE_MONITOR_STALL_COUNT_EN
        read_check("stalls_pw_5", 4'd8, 32'd5);
        check("stalls_invalid", {31'd0, last_inv}, 32'd0);
        read_check("status_stall", 4'd1, 32'h10);
`else
        read_check("addr8_zero", 4'd8, 32'd0);
        check("addr8_invalid", {31'd0, last_inv}, 32'd0);
        check("addr8_ack", {31'd0, last_ack}, 32'd1);
        read_check("status_no_stall", 4'd1, 32'h0);
`endif

        // ---------------- invalid address, write priority ----------------
        read_check("version_pre", 4'd9, 32'h1100_0000);
        read_check("inv_rd_data", 4'd12, 32'd0);
        check("inv_rd_flag", {31'd0, last_inv}, 32'd1);
        check("inv_rd_ack", {31'd0, last_ack}, 32'd1);
        @(negedge i_axi_clk);
        check("ack_one_cycle", {30'd0, o_reg_ack, o_reg_invalid}, 32'd0);
        reg_write(4'd12, 32'hFFFF_FFFF);
        check("inv_wr_flag", {31'd0, last_inv}, 32'd1);
        read_check("version_again", 4'd9, 32'h1100_0000);
        i_reg_wr_stb = 1'b1; i_reg_rd_stb = 1'b1; i_reg_addr = 4'd2; i_reg_wr_data = 32'd77;
        @(negedge i_axi_clk);
        i_reg_wr_stb = 1'b0; i_reg_rd_stb = 1'b0;
        check("wr_rd_ack", {31'd0, o_reg_ack}, 32'd1);
        check("wr_rd_dropped", o_reg_rd_data, 32'h1100_0000);
        @(negedge i_axi_clk);
        check("wr_rd_single_ack", {31'd0, o_reg_ack}, 32'd0);
        read_check("wr_rd_window", 4'd2, 32'd77);
        reg_write(4'd9, 32'd0);
        reg_write(4'd3, 32'hFFFF);
        read_check("ro_version", 4'd9, 32'h1100_0000);
        read_check("ro_total_frames", 4'd3, 32'd1);

        // ---------------- enable freeze ----------------
        reg_write(4'd0, 32'd0);
        read_check("ctrl_disabled", 4'd0, 32'd0);
        send_line(4, 1'b1);
        read_check("freeze_tf", 4'd3, 32'd1);
        read_check("freeze_ppl", 4'd7, 32'd8);
        reg_write(4'd0, 32'd2);

        // ---------------- set beats clear ----------------
        reg_write(4'd1, 32'h1F);
        i_reg_wr_stb = 1'b1; i_reg_addr = 4'd1; i_reg_wr_data = 32'h1F;
        i_axis_in_tvalid = 1'b1; i_axis_in_tuser = 1'b1;
        @(negedge i_axi_clk);
        i_reg_wr_stb = 1'b0; i_axis_in_tvalid = 1'b0; i_axis_in_tuser = 1'b0;
        reg_read(4'd1, rd);
        check("set_wins_bit0", rd & 32'h1, 32'h1);
        read_check("set_wins_tf", 4'd3, 32'd2);

        // ---------------- mid-frame reset ----------------
        read_check("ppl_before_rst", 4'd7, 32'd8);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0);
        i_axi_rst = 1'b1;
        @(negedge i_axi_clk);
        check("rst2_rd_data", o_reg_rd_data, 32'd0);
        i_axi_rst = 1'b0;
        @(negedge i_axi_clk);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        read_check("partial_ppl", 4'd7, 32'd2);
        read_check("partial_status", 4'd1, 32'd0);
        read_check("rst2_window", 4'd2, 32'd100000000);
        read_check("rst2_control", 4'd0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
